cgra_config_sequencer: RTL and testbench

Hardware config-bus master that replaces testbench-driven bitstream loading for the CGRA `Interconnect`. It consumes a valid/ready command stream (write, read-check, stall control, flush pulse, wait, done) and drives the shared `config_*` bus and per-column `stall`. It sits between the GLB/SoC-side bitstream DMA and the `Interconnect` config ports. It generalises column count, address/data width and readback latency, and adds on-chip readback checking with error logging.

---
 rtl/cgra_cfg_pkg.sv | 26 ++
 rtl/cfg_readback_checker.sv | 55 +++++
 rtl/cgra_config_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cgra_config_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA config-bus sequencer: opcodes, FSM states, error counter width.
package cgra_cfg_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_WRITE      = 3'd0,
        OP_READ_CHECK = 3'd1,
        OP_STALL_SET  = 3'd2,
        OP_PULSE      = 3'd3,
        OP_WAIT       = 3'd4,
        OP_DONE       = 3'd5,
        OP_RSVD6      = 3'd6,
        OP_RSVD7      = 3'd7
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_PULSE_HI = 3'd3,
        ST_PULSE_LO = 3'd4,
        ST_WAIT     = 3'd5
    } cfg_state_e;

endpackage

// File: rtl/cfg_readback_checker.sv
// Compares sampled readback data against the expected word and keeps sticky error state:
// flag, saturating mismatch count and the address of the first mismatch.
module cfg_readback_checker
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [DATA_W-1:0]    rdata,
    input  logic [DATA_W-1:0]    exp_data,
    input  logic [ADDR_W-1:0]    addr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr
);

    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 mismatch;

    assign mismatch = sample_en && (rdata != exp_data);

    always_comb begin
        err_d  = err_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != {ERR_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            // Only the first mismatch since reset is recorded.
            if (!err_q) addr_d = addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign err       = err_q;
    assign err_count = cnt_q;
    assign err_addr  = addr_q;

endmodule

// File: rtl/cgra_config_sequencer.sv
// Config-bus master for the CGRA Interconnect, driven by a command stream.
// Build option CFG_SEQ_READBACK_EN enables READ_CHECK readback comparison and error logging.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                NUM_COLS       = 4,
    parameter int                READ_LAT       = 1,
    parameter int                PULSE_LEN      = 2,
    parameter logic [DATA_W-1:0] PULSE_CLR_MASK = DATA_W'(32'h0000_FFFF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_data,
    output logic [ADDR_W-1:0]    config_config_addr,
    output logic [DATA_W-1:0]    config_config_data,
    output logic                 config_write,
    output logic                 config_read,
    input  logic [DATA_W-1:0]    read_config_data,
    output logic [NUM_COLS-1:0]  stall,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    err_addr
);

    // Handshake: a command transfers on any rising edge where cmd_valid and cmd_ready are
    // both high; cmd_ready is high exactly while the FSM is idle and does not depend on cmd_valid.
    cfg_state_e          state_q, state_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                write_q, write_d;
    logic                read_q, read_d;
    logic [NUM_COLS-1:0] stall_q, stall_d;
    logic                done_q, done_d;
    logic                fire;
    cfg_op_e             op;

    assign op   = cfg_op_e'(cmd_op);
    assign fire = cmd_valid && cmd_ready;

`ifdef CFG_SEQ_READBACK_EN
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              sample_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            stall_q <= {NUM_COLS{1'b1}};
            done_q  <= 1'b0;
`ifdef CFG_SEQ_READBACK_EN
            exp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            read_q  <= read_d;
            stall_q <= stall_d;
            done_q  <= done_d;
`ifdef CFG_SEQ_READBACK_EN
            exp_q   <= exp_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    case (op)
                        OP_WRITE: state_d = ST_WRITE;
`ifdef CFG_SEQ_READBACK_EN
                        OP_READ_CHECK: begin
                            state_d = ST_READ;
                            cnt_d   = DATA_W'(READ_LAT - 1);
                        end
`endif
                        OP_PULSE: begin
                            state_d = ST_PULSE_HI;
                            cnt_d   = DATA_W'(PULSE_LEN - 1);
                        end
                        OP_WAIT: begin
                            // A zero count never leaves IDLE.
                            if (cmd_data != '0) begin
                                state_d = ST_WAIT;
                                cnt_d   = cmd_data - DATA_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE:    state_d = ST_IDLE;
            ST_PULSE_LO: state_d = ST_IDLE;
            ST_READ, ST_PULSE_HI, ST_WAIT: begin
                if (cnt_q == '0) state_d = (state_q == ST_PULSE_HI) ? ST_PULSE_LO : ST_IDLE;
                else             cnt_d   = cnt_q - DATA_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = 1'b0;
        read_d  = 1'b0;
        stall_d = stall_q;
        done_d  = done_q;
`ifdef CFG_SEQ_READBACK_EN
        exp_d   = exp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    case (op)
                        OP_WRITE, OP_PULSE: begin
                            addr_d  = cmd_addr;
                            data_d  = cmd_data;
                            write_d = 1'b1;
                        end
`ifdef CFG_SEQ_READBACK_EN
                        OP_READ_CHECK: begin
                            addr_d = cmd_addr;
                            read_d = 1'b1;
                            exp_d  = cmd_data;
                        end
`endif
                        OP_STALL_SET: stall_d = cmd_data[NUM_COLS-1:0];
                        OP_DONE:      done_d  = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_READ: read_d = (cnt_q != '0);
            ST_PULSE_HI: begin
                write_d = 1'b1;
                if (cnt_q == '0) data_d = data_q & ~PULSE_CLR_MASK;
            end
            default: ;
        endcase
    end

`ifdef CFG_SEQ_READBACK_EN
    // Readback is sampled on the last cycle of the read strobe window.
    assign sample_en = (state_q == ST_READ) && (cnt_q == '0);

    cfg_readback_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk       (clk),
        .rst       (reset),
        .sample_en (sample_en),
        .rdata     (read_config_data),
        .exp_data  (exp_q),
        .addr      (addr_q),
        .err       (err),
        .err_count (err_count),
        .err_addr  (err_addr)
    );
`else
    logic unused_readback;
    assign unused_readback = ^{read_config_data, 4'(READ_LAT)};
    assign err       = 1'b0;
    assign err_count = '0;
    assign err_addr  = '0;
`endif

    assign cmd_ready          = (state_q == ST_IDLE);
    assign busy               = (state_q != ST_IDLE);
    assign config_config_addr = addr_q;
    assign config_config_data = data_q;
    assign config_write       = write_q;
    assign config_read        = read_q;
    assign stall              = stall_q;
    assign done               = done_q;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench for cgra_config_sequencer: scoreboard of expected bus transactions,
// bench-side SRAM model for readback, latency checks per command.
module tb_cgra_config_sequencer;
  import cgra_cfg_pkg::*;

  localparam int READ_LAT  = 1;
  localparam int PULSE_LEN = 2;
  localparam logic [31:0] CLR_MASK = 32'h0000_FFFF;
`ifdef CFG_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int EW = 65;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] config_config_addr;
  logic [31:0] config_config_data;
  logic        config_write;
  logic        config_read;
  logic [31:0] read_config_data = 32'h0;
  logic [3:0]  stall;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   sram[logic [31:0]];
  bit            rb_force = 1'b0;
  logic [31:0]   rb_val = 32'h0;
  int            n_cmp = 0;
  int            n_fail = 0;

  cgra_config_sequencer #(
    .ADDR_W(32), .DATA_W(32), .NUM_COLS(4), .READ_LAT(READ_LAT),
    .PULSE_LEN(PULSE_LEN), .PULSE_CLR_MASK(CLR_MASK)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .config_config_addr(config_config_addr), .config_config_data(config_config_data),
    .config_write(config_write), .config_read(config_read),
    .read_config_data(read_config_data), .stall(stall), .busy(busy), .done(done),
    .err(err), .err_count(err_count), .err_addr(err_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bus monitor / scoreboard and SRAM readback model
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] obs;
    if (!reset) begin
      if (rb_force) read_config_data = rb_val;
      else if (sram.exists(config_config_addr)) read_config_data = sram[config_config_addr];
      else read_config_data = 32'h0;
      if (config_write || config_read) begin
        check("strobe_exclusive", {config_write, config_read} == 2'b11, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {config_write, config_read}, 2'b00);
        end else begin
          e   = exp_q.pop_front();
          obs = config_read ? {1'b1, config_config_addr, 32'h0}
                            : {1'b0, config_config_addr, config_config_data};
          check("bus_txn", obs, e);
        end
      end
    end
  end

  // driver: must be entered at a negedge; returns at the negedge where cmd_ready is seen again
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input string tag);
    int wt;
    int lat;
    case (op)
      OP_WRITE: begin
        exp_q.push_back({1'b0, a, d});
        sram[a] = d;
      end
      OP_READ_CHECK: if (RB) for (int i = 0; i < READ_LAT; i++) exp_q.push_back({1'b1, a, 32'h0});
      OP_PULSE: begin
        for (int i = 0; i < PULSE_LEN; i++) exp_q.push_back({1'b0, a, d});
        exp_q.push_back({1'b0, a, d & ~CLR_MASK});
      end
      default: ;
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    wt = 0;
    while (!cmd_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check({tag, "_ready"}, cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (exp_lat > 0) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!cmd_ready && lat < 5000);
      check({tag, "_latency"}, lat, exp_lat);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_write"}, config_write, 1'b0);
    check({tag, "_read"}, config_read, 1'b0);
    check({tag, "_stall"}, stall, 4'hF);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, {err, err_count, err_addr}, '0);
  endtask

  initial begin
    int rd_lat;
    logic [31:0] a;
    rd_lat = RB ? READ_LAT + 1 : 1;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_addr = 32'h0;
    cmd_data = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    check("rst_bus", {config_config_addr, config_config_data}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // single write
    check("stall_before_write", stall, 4'hF);
    send(OP_WRITE, 32'h0000_0302, 32'h001C_0000, 2, "wr0");
    check("wr0_hold", {config_write, config_config_addr, config_config_data},
          {1'b0, 32'h0000_0302, 32'h001C_0000});

    // bulk writes then readback against the SRAM model
    for (int cnt = 0; cnt < 512; cnt++) begin
      a = {cnt[7:0], 8'h01, 16'h0201};
      send(OP_WRITE, a, 32'h0000_0099, 2, "bulk_wr");
    end
    for (int cnt = 0; cnt < 512; cnt++) begin
      a = {cnt[7:0], 8'h01, 16'h0201};
      send(OP_READ_CHECK, a, 32'h0000_0099, rd_lat, "bulk_rd");
    end
    send(OP_DONE, 32'h0, 32'h0, 1, "done");
    check("bulk_err", {err, err_count}, 17'h0);
    check("done_set", done, 1'b1);

    // two readback mismatches
    rb_force = 1'b1;
    rb_val   = 32'h0000_0013;
    send(OP_READ_CHECK, 32'h0000_1000, 32'h0000_0012, rd_lat, "mm_a");
    check("mm_a_count", err_count, RB ? 16'd1 : 16'd0);
    send(OP_READ_CHECK, 32'h0000_2000, 32'h0000_0012, rd_lat, "mm_b");
    rb_force = 1'b0;
    check("mm_err", err, RB);
    check("mm_count", err_count, RB ? 16'd2 : 16'd0);
    check("mm_addr", err_addr, RB ? 32'h0000_1000 : 32'h0);
    check("done_sticky", done, 1'b1);

    // pulse and stall release
    send(OP_PULSE, 32'h0000_0302, 32'h001C_7E00, PULSE_LEN + 2, "pulse");
    send(OP_STALL_SET, 32'h0, 32'h0, 1, "stall0");
    check("stall_cleared", stall, 4'h0);
    send(OP_STALL_SET, 32'h0, 32'h0000_000A, 1, "stallA");
    check("stall_a", stall, 4'hA);

    // waits and a reserved opcode
    send(OP_WAIT, 32'h0, 32'd0, 1, "wait0");
    send(OP_WAIT, 32'h0, 32'd2000, 2001, "wait2000");
    send(3'd6, 32'h0000_0777, 32'h0000_0555, 1, "rsvd6");
    check("rsvd_bus_hold", {config_config_addr, config_config_data},
          {32'h0000_0302, 32'h001C_0000});
    check("sb_drain_pre_reset", exp_q.size(), 0);

    // asynchronous reset during PULSE_HI
    send(OP_PULSE, 32'h0000_0302, 32'h001C_7E00, 0, "pulse_rst");
    @(negedge clk);
    #2;
    check("pulse_hi_active", config_write, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("post_rst_idle", {config_write, config_read, busy}, 3'b000);

    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
